// File: rtl/module_operand_buffer.sv
// Double-buffered BCD operand register: keypad entry side plus a
// committed output side handed over with valid/ready. Option: OPERAND_BLANK_EN.
module module_operand_buffer #(
    parameter int N         = 4,
    parameter int DIGITS    = 2,
    parameter int MAX_DIGIT = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           key_valid,
    input  logic [N-1:0]                   key_digit,
    input  logic                           key_del,
    input  logic                           key_clr,
    input  logic                           commit,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [DIGITS*N-1:0]            out_digits,
    output logic [DIGITS*N-1:0]            entry_digits,
    output logic [$clog2(DIGITS+1)-1:0]    count,
    output logic                           full,
`ifdef OPERAND_BLANK_EN
    output logic [DIGITS-1:0]              out_blank,
`endif
    output logic                           err
);

    localparam int W  = DIGITS * N;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t state;

    logic digit_ok;
    logic commit_ok;
    logic commit_err;
    logic del_err;
    logic key_err;
    logic entry_err;

    assign full     = (count == CW'(DIGITS));
    assign digit_ok = (key_digit <= N'(MAX_DIGIT));

    // A commit lands only with a non-empty entry and a free (or freeing) output.
    assign commit_ok  = commit && (count != '0) &&
                        ((state == EMPTY) || out_ready);
    assign commit_err = commit && !commit_ok;

    assign del_err   = !key_clr && key_del && (count == '0);
    assign key_err   = !key_clr && !key_del && key_valid &&
                       (full || !digit_ok);
    // Strobes overridden by an accepted commit are dropped without error.
    assign entry_err = !commit_ok && (del_err || key_err);

`ifdef OPERAND_BLANK_EN
    logic [DIGITS-1:0] blank_next;

    // Mark positions at or above the digit count as unused leading digits.
    always_comb begin
        blank_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            blank_next[i] = (i >= int'(count));
        end
    end
`endif

    // Entry register: commit clears it, else clr > del > key.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_digits <= '0;
            count        <= '0;
        end else if (commit_ok || key_clr) begin
            entry_digits <= '0;
            count        <= '0;
        end else if (key_del) begin
            if (count != '0) begin
                entry_digits <= entry_digits >> N;
                count        <= count - CW'(1);
            end
        end else if (key_valid && digit_ok && !full) begin
            entry_digits <= (entry_digits << N) | W'(key_digit);
            count        <= count + CW'(1);
        end
    end

    // Output FSM with registered valid, operand and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            out_digits <= '0;
            err        <= 1'b0;
`ifdef OPERAND_BLANK_EN
            out_blank  <= '1;
`endif
        end else begin
            err <= commit_err || entry_err;
            if (commit_ok) begin
                out_digits <= entry_digits;
`ifdef OPERAND_BLANK_EN
                out_blank  <= blank_next;
`endif
            end
            unique case (state)
                EMPTY: begin
                    if (commit_ok) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!commit_ok && out_ready) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_operand_buffer.sv
// Bench for module_operand_buffer: digit-queue model checked every cycle
// plus directed literal expectations.
module tb_module_operand_buffer;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int MX = 9;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key_valid = 1'b0;
    logic [N-1:0] key_digit = '0;
    logic         key_del = 1'b0;
    logic         key_clr = 1'b0;
    logic         commit = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [7:0]   out_digits;
    logic [7:0]   entry_digits;
    logic [1:0]   count;
    logic         full;
    logic         err;
`ifdef OPERAND_BLANK_EN
    logic [1:0]   out_blank;
`endif

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    module_operand_buffer #(.N(N), .DIGITS(D), .MAX_DIGIT(MX)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_digit(key_digit),
        .key_del(key_del), .key_clr(key_clr),
        .commit(commit), .out_ready(out_ready),
        .out_valid(out_valid), .out_digits(out_digits),
        .entry_digits(entry_digits), .count(count),
        .full(full),
`ifdef OPERAND_BLANK_EN
        .out_blank(out_blank),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    // Model: entry held as a list of digits, most recent first.
    int   ent[$];
    int   m_out;
    bit   m_valid;
    bit   m_err;
    int   m_blank;

    function automatic int ent_val();
        int v = 0;
        foreach (ent[k]) v += ent[k] * (16 ** k);
        return v;
    endfunction

    always @(posedge clk) begin
        bit e;
        bit take;
        if (rst) begin
            ent.delete();
            m_out = 0; m_valid = 0; m_err = 0; m_blank = 3;
        end else begin
            e = 0;
            take = commit && ent.size() > 0 && (!m_valid || out_ready);
            if (commit && !take) e = 1;
            if (take) begin
                m_out = ent_val();
                m_blank = 0;
                for (int i = 0; i < D; i++)
                    if (i >= ent.size()) m_blank += (1 << i);
                ent.delete();
                m_valid = 1;
            end else begin
                if (m_valid && out_ready) m_valid = 0;
                if (key_clr) ent.delete();
                else if (key_del) begin
                    if (ent.size() == 0) e = 1;
                    else void'(ent.pop_front());
                end else if (key_valid) begin
                    if (ent.size() == D || int'(key_digit) > MX) e = 1;
                    else ent.push_front(int'(key_digit));
                end
            end
            m_err = e;
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_out_valid", int'(out_valid), int'(m_valid));
            check("m_out_digits", int'(out_digits), m_out);
            check("m_entry", int'(entry_digits), ent_val());
            check("m_count", int'(count), ent.size());
            check("m_full", int'(full), int'(ent.size() == D));
            check("m_err", int'(err), int'(m_err));
`ifdef OPERAND_BLANK_EN
            check("m_blank", int'(out_blank), m_blank);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input int d);
        key_valid = 1; key_digit = N'(d);
        cyc();
        key_valid = 0;
    endtask

    task automatic del();
        key_del = 1;
        cyc();
        key_del = 0;
    endtask

    task automatic cmt();
        commit = 1;
        cyc();
        commit = 0;
    endtask

    initial begin
        rst = 1;
        cyc(); cyc();
        rst = 0;
        chk_en = 1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_count", int'(count), 0);
        check("rst_out", int'(out_digits), 0);
        check("rst_err", int'(err), 0);

        // 1: fill, then overflow
        key(7); key(3);
        check("t1_entry", int'(entry_digits), 'h73);
        check("t1_count", int'(count), 2);
        check("t1_full", int'(full), 1);
        key(5);
        check("t1_err", int'(err), 1);
        check("t1_keep", int'(entry_digits), 'h73);
        cyc();
        check("t1_err_end", int'(err), 0);

        // 2: commit and stall
        cmt();
        check("t2_valid", int'(out_valid), 1);
        check("t2_out", int'(out_digits), 'h73);
        check("t2_entry", int'(entry_digits), 0);
        check("t2_count", int'(count), 0);
        repeat (5) cyc();
        check("t2_stable", int'(out_digits), 'h73);
        check("t2_still", int'(out_valid), 1);
        out_ready = 1;
        cyc();
        out_ready = 0;
        check("t2_drain", int'(out_valid), 0);
        check("t2_retain", int'(out_digits), 'h73);

        // 3: delete and illegal digit
        key(4); del();
        check("t3_entry", int'(entry_digits), 0);
        check("t3_count", int'(count), 0);
        del();
        check("t3_del_err", int'(err), 1);
        key('hB);
        check("t3_bad_err", int'(err), 1);
        check("t3_bad_cnt", int'(count), 0);
        key(9);
        check("t3_nine", int'(entry_digits), 'h09);
        key('hA);
        check("t3_a_err", int'(err), 1);
        key_clr = 1; cyc(); key_clr = 0;

        // 4: back-to-back commit, then stalled commit
        key(7); key(3); cmt();
        key(1); key(2);
        check("t4_entry", int'(entry_digits), 'h12);
        out_ready = 1;
        cmt();
        check("t4_valid", int'(out_valid), 1);
        check("t4_out", int'(out_digits), 'h12);
        out_ready = 0;
        key(4);
        cmt();
        check("t4_rej_err", int'(err), 1);
        check("t4_keep", int'(entry_digits), 'h04);
        check("t4_out_keep", int'(out_digits), 'h12);
        out_ready = 1; cyc(); out_ready = 0;
        check("t4_drain", int'(out_valid), 0);

        // 5: clr beats key, empty commit rejected
        key_clr = 1; key_valid = 1; key_digit = 5;
        cyc();
        key_clr = 0; key_valid = 0;
        check("t5_entry", int'(entry_digits), 0);
        check("t5_count", int'(count), 0);
        cmt();
        check("t5_err", int'(err), 1);
        check("t5_valid", int'(out_valid), 0);

        // del beats key; commit drops concurrent key silently
        key(2);
        key_del = 1; key_valid = 1; key_digit = 8;
        cyc();
        key_del = 0; key_valid = 0;
        check("pri_del", int'(entry_digits), 0);
        key(5);
        commit = 1; key_valid = 1; key_digit = 6;
        cyc();
        commit = 0; key_valid = 0;
        check("drop_out", int'(out_digits), 'h05);
        check("drop_entry", int'(entry_digits), 0);
        check("drop_err", int'(err), 0);

        // 6: reset during stalled hold
        key(8);
        rst = 1; cyc(); rst = 0;
        check("t6_valid", int'(out_valid), 0);
        check("t6_out", int'(out_digits), 0);
        check("t6_count", int'(count), 0);
`ifdef OPERAND_BLANK_EN
        check("t6_blank_rst", int'(out_blank), 3);
        key(6); cmt();
        check("t6_blank", int'(out_blank), 2);
`endif
        cyc(); cyc();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/module_operand_buffer.md
Name: module_operand_buffer

Overview:
Parametrised, double-buffered operand register, successor to the single enabled flip-flop.
- Keypad digits are shifted into an entry register with delete and clear.
- A commit copies the entry register into an output register that holds the committed operand for the display system.
- The output register is handed over with a valid/ready handshake, and out_valid stays high until the display accepts the operand.

Parameters:
N, 4, bits per digit (BCD).
DIGITS, 2, number of digits held (e.g. units and tens).
MAX_DIGIT, 9, largest legal digit code; codes above it are rejected.

Ports:
clk  input  1  system clock, all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
key_valid  input  1  one-cycle strobe: key_digit is a new digit.
key_digit  input  N  digit code, sampled when key_valid=1.
key_del  input  1  strobe: remove the most recently entered digit.
key_clr  input  1  strobe: clear the entry register.
commit  input  1  strobe: transfer the entry register to the output register.
out_ready  input  1  display consumer accepts out_digits.
out_valid  output  1  out_digits holds a committed, unaccepted operand.
out_digits  output  DIGITS*N  committed operand; digit 0 (units) in bits [N-1:0].
entry_digits  output  DIGITS*N  live entry register, for echo display.
count  output  $clog2(DIGITS+1)  number of digits currently in the entry register.
full  output  1  count==DIGITS (combinational from count).
err  output  1  one-cycle pulse when an input is rejected.

Behaviour:
- Reset (rst=1 at a clock edge):
  - entry_digits=0, out_digits=0, count=0, out_valid=0, err=0, state=EMPTY.
  - rst overrides every other input in the same cycle, including a handshake in progress.
- Entry-side priority within one cycle: key_clr > key_del > key_valid. Only the highest-priority active strobe acts. commit is evaluated independently and samples the entry register's pre-edge value.
- key_clr: entry_digits=0, count=0 on the next edge. It has no effect on the output side.
- key_del:
  - count>0: entry shifts right by N, MSB digit becomes 0, count-1.
  - count==0: no change, err pulse.
- key_valid:
  - key_digit<=MAX_DIGIT and count<DIGITS: entry shifts left by N, key_digit enters digit 0, count+1.
  - full, or key_digit>MAX_DIGIT: entry and count are unchanged, err pulse.
- Output FSM, two states:
  - EMPTY: out_valid=0.
  - HOLD: out_valid=1; out_digits is stable and must not change while out_valid=1 and out_ready=0.
- EMPTY + commit with count>0:
  - next edge: out_digits=entry_digits (pre-edge value), state=HOLD.
  - same edge: entry_digits=0 and count=0. This overrides any concurrent entry-side strobe, which is dropped silently.
- EMPTY + commit with count==0: ignored, err pulse.
- HOLD + out_ready=1, no commit: next edge out_valid=0, state=EMPTY; out_digits retains its last value.
- HOLD + out_ready=1 + commit with count>0 (same cycle): the new operand loads, out_valid stays 1, state stays HOLD. This gives back-to-back transfer with no bubble.
- HOLD + out_ready=0 + commit: commit is rejected, err pulse, entry register preserved.
- Entry editing is allowed in both states, so the next operand can be typed while the previous one is held.
- Latency:
  - entry_digits, count: 1 cycle after strobe.
  - out_valid, out_digits: 1 cycle after commit.
  - err: registered, asserted the cycle after the offending strobe, for exactly 1 cycle. Multiple simultaneous rejections still give a single pulse.
- Digit count never wraps: count is saturated at DIGITS and at 0 by the rules above.

Optional Feature:
- Macro: OPERAND_BLANK_EN.
- Defined:
  - Adds output out_blank, width DIGITS, registered alongside out_digits on each accepted commit.
  - Bit i = 1 when i >= count at commit time, marking unused leading positions so the display can blank them instead of showing 0.
  - Reset value: all ones.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan (N=4, DIGITS=2, MAX_DIGIT=9):
1. Reset, then key 7, key 3 -> entry_digits=0x73, count=2, full=1; key 5 -> err pulse, entry still 0x73.
2. Entry 0x73, commit -> next cycle out_valid=1, out_digits=0x73, entry=0, count=0; hold out_ready=0 for 5 cycles -> out_digits stable at 0x73; out_ready=1 -> out_valid=0 next cycle.
3. key 4, key_del -> entry=0x00, count=0; key_del again -> err pulse; key_digit=0xB -> err pulse, count=0.
4. HOLD with 0x73, type 1,2, then commit with out_ready=1 in the same cycle -> out_valid stays 1, out_digits=0x12; commit with out_ready=0 -> err, entry preserved.
5. key_clr + key_valid(5) in the same cycle -> entry=0, count=0; commit with count=0 -> err, out_valid remains 0.
6. rst asserted during HOLD with out_ready=0 -> next cycle out_valid=0, out_digits=0, count=0. With OPERAND_BLANK_EN: commit of the single digit 6 -> out_blank=2'b10.
